// File: rtl/fsm_secuenciador_etapas.sv
// Stage sequencer: issues start/ack handshakes to N_STAGES blocks in index order, with skip, loop and abort.
// Optional ack watchdog built when FSM_SEC_WATCHDOG_EN is defined.
module fsm_secuenciador_etapas #(
    parameter int unsigned N_STAGES = 5,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned PASS_W   = 8,
    parameter int unsigned TO_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                loop_mode,
    input  logic                abort,
    input  logic [N_STAGES-1:0] stage_mask,
    input  logic [TO_W-1:0]     to_limit,
    input  logic [N_STAGES-1:0] ack,
    output logic [N_STAGES-1:0] start,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [IDX_W-1:0]    stage_idx,
    output logic [PASS_W-1:0]   pass_cnt
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    state_t                state_q, state_n;
    logic [N_STAGES-1:0]   mask_q, mask_n;
    logic [IDX_W-1:0]      idx_n;
    logic [IDX_W-1:0]      first_idx, nxt_idx;
    logic                  nxt_found;
    logic                  ack_hit;
    logic                  wd_trip;
    logic [N_STAGES-1:0]   start_n;
    logic                  busy_n, done_n, error_n;

    assign ack_hit = |(ack & (N_STAGES'(1) << stage_idx));

    // Lowest enabled stage of the incoming mask, and next enabled stage above the current one.
    always_comb begin
        first_idx = '0;
        nxt_idx   = stage_idx;
        nxt_found = 1'b0;
        for (int i = int'(N_STAGES) - 1; i >= 0; i--) begin
            if (stage_mask[i]) first_idx = IDX_W'(i);
            if (mask_q[i] && (i > int'(stage_idx))) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(i);
            end
        end
    end

`ifdef FSM_SEC_WATCHDOG_EN
    logic [TO_W-1:0] wd_cnt;

    // Trips on the WAIT cycle whose count would reach the limit.
    assign wd_trip = (to_limit != '0) && (TO_W'(wd_cnt + TO_W'(1)) == to_limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state_q == ISSUE) begin
            wd_cnt <= '0;
        end else if ((state_q == WAIT) && !ack_hit) begin
            wd_cnt <= wd_cnt + TO_W'(1);
        end
    end
`else
    logic unused_to_limit;
    assign unused_to_limit = ^to_limit;
    assign wd_trip         = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            stage_idx <= '0;
            start     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            pass_cnt  <= '0;
        end else begin
            state_q   <= state_n;
            mask_q    <= mask_n;
            stage_idx <= idx_n;
            start     <= start_n;
            busy      <= busy_n;
            done      <= done_n;
            error     <= error_n;
            if (state_n == DONE) pass_cnt <= pass_cnt + PASS_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        mask_n  = mask_q;
        idx_n   = stage_idx;
        case (state_q)
            IDLE: begin
                if (run) begin
                    mask_n = stage_mask;
                    if (|stage_mask) begin
                        state_n = ISSUE;
                        idx_n   = first_idx;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (ack_hit) begin
                    if (nxt_found) begin
                        state_n = ISSUE;
                        idx_n   = nxt_idx;
                    end else begin
                        state_n = DONE;
                    end
                end else if (wd_trip) begin
                    state_n = ERR;
                end
            end
            DONE: begin
                if (loop_mode && run) begin
                    mask_n = stage_mask;
                    if (|stage_mask) begin
                        state_n = ISSUE;
                        idx_n   = first_idx;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ERR:     state_n = ERR;
            default: state_n = IDLE;
        endcase
        // Abort overrides ack and watchdog; index and latched mask are kept.
        if (abort) begin
            state_n = IDLE;
            mask_n  = mask_q;
            idx_n   = stage_idx;
        end
    end

    // Output values for the upcoming state.
    always_comb begin
        start_n = '0;
        if (state_n == ISSUE) start_n = N_STAGES'(1) << idx_n;
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
`ifdef FSM_SEC_WATCHDOG_EN
        error_n = (state_n == ERR);
`else
        error_n = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fsm_secuenciador_etapas.sv
// Self-checking bench for fsm_secuenciador_etapas: vector table of passes, scoreboard of start/done events,
// plus hand-written loop, abort, watchdog and reset sequences.
module tb_fsm_secuenciador_etapas;

    logic       clk = 1'b0;
    logic       reset;
    logic       run, loop_mode, abort;
    logic [4:0] stage_mask, ack, start;
    logic [7:0] to_limit, pass_cnt;
    logic       busy, done, error;
    logic [3:0] stage_idx;

    fsm_secuenciador_etapas dut (
        .clk(clk), .reset(reset), .run(run), .loop_mode(loop_mode), .abort(abort),
        .stage_mask(stage_mask), .to_limit(to_limit), .ack(ack), .start(start),
        .busy(busy), .done(done), .error(error), .stage_idx(stage_idx), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] mask; int dly; } vec_t;
    vec_t vecs [6];

    int         q[$];
    int         n_chk = 0, n_err = 0;
    int         cyc = 0, last_done = -10, n_done = 0, exp_pass = 0;
    int         delay = 1, pend_cnt = 0, pend_idx = 0;
    logic       pend = 1'b0;
    logic [4:0] mute = '0, stray = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe outputs after the edge, score events, drive the stage acks.
    task automatic tick();
        int idx, e;
        @(posedge clk);
        #1;
        cyc++;
        ack = stray;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                ack[pend_idx] = 1'b1;
                pend = 1'b0;
            end
        end
        if (start != '0) begin
            chk("start_onehot", 32'($countones(start)), 32'd1);
            idx = 0;
            for (int i = 0; i < 5; i++) if (start[i]) idx = i;
            if (q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL start_unexpected: got start on stage %0d, expected none (cycle %0d)", idx, cyc);
            end else begin
                e = q.pop_front();
                chk("start_idx", 32'(idx), 32'(e));
                chk("stage_idx", 32'(stage_idx), 32'(e));
            end
            if (!mute[idx]) begin
                pend     = 1'b1;
                pend_cnt = delay;
                pend_idx = idx;
            end
        end
        if (done) begin
            n_done++;
            last_done = cyc;
            if (q.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL done_unexpected: got done with pass_cnt %0d, expected none", pass_cnt);
            end else begin
                e = q.pop_front();
                chk("done_event", 32'(100 + int'(pass_cnt)), 32'(e));
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: got busy=1 after %0d cycles, expected 0", name, n);
        end
    endtask

    // Single pass with run pulsed for one edge; the expected sequence is the enabled stages in order.
    task automatic run_vec(input logic [4:0] m, input int dly);
        logic [4:0] low;
        delay = dly;
        stray = ~m;
        stage_mask = m;
        for (int i = 0; i < 5; i++) if (m[i]) q.push_back(i);
        exp_pass++;
        q.push_back(100 + exp_pass);
        low = m & (~m + 5'd1);
        run = 1'b1;
        tick();
        run = 1'b0;
        stage_mask = ~m;
        if (m != '0) chk("latency_start", 32'(start), 32'(low));
        else         chk("latency_done", 32'(done), 32'd1);
        wait_idle("pass");
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
        chk("busy_fall", 32'(cyc), 32'(last_done + 1));
        stray = '0;
    endtask

    // Run stages 0,1 with stage 1 muted; returns on the cycle start[1] is seen.
    task automatic stall_on_stage1();
        int n = 0;
        mute = 5'b00010;
        delay = 1;
        stage_mask = 5'b00011;
        q.push_back(0);
        q.push_back(1);
        run = 1'b1;
        tick();
        run = 1'b0;
        while (start[1] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("stall_start1", 32'(start[1]), 32'd1);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    endtask

    initial begin
        int  n;
        logic prev_done;

        vecs[0] = '{5'b11111, 2};
        vecs[1] = '{5'b10101, 2};
        vecs[2] = '{5'b00000, 1};
        vecs[3] = '{5'b10000, 1};
        vecs[4] = '{5'b00001, 3};
        vecs[5] = '{5'b01110, 1};

        reset = 1'b1; run = 1'b0; loop_mode = 1'b0; abort = 1'b0;
        stage_mask = '0; ack = '0; to_limit = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_stage_idx", 32'(stage_idx), 32'd0);
        chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) run_vec(vecs[v].mask, vecs[v].dly);

        // Loop mode: three passes, run dropped during the third.
        delay = 1; stray = 5'b11100; stage_mask = 5'b00011; loop_mode = 1'b1;
        for (int p = 0; p < 3; p++) begin
            q.push_back(0);
            q.push_back(1);
            exp_pass++;
            q.push_back(100 + exp_pass);
        end
        n_done = 0; prev_done = 1'b0; n = 0;
        run = 1'b1;
        while (n_done < 3 && n < 100) begin
            tick();
            n++;
            if (prev_done) chk("loop_restart", 32'(start), 32'd1);
            prev_done = done && (n_done < 3);
            if (n_done == 2 && start != '0) run = 1'b0;
        end
        chk("loop_done_count", 32'(n_done), 32'd3);
        loop_mode = 1'b0;
        wait_idle("loop");
        chk("loop_queue_empty", 32'(q.size()), 32'd0);
        chk("loop_pass_cnt", 32'(pass_cnt), 32'(exp_pass));
        chk("loop_busy_fall", 32'(cyc), 32'(last_done + 1));
        stray = '0;

        // Abort while waiting on stage 2, then a fresh pass from stage 0.
        mute = 5'b00100; delay = 1; stage_mask = 5'b11111;
        q.push_back(0); q.push_back(1); q.push_back(2);
        run = 1'b1;
        tick();
        run = 1'b0;
        n = 0;
        while (start[2] !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("abort_reach_stage2", 32'(start[2]), 32'd1);
        tick();
        do_abort();
        chk("abort_stage_idx", 32'(stage_idx), 32'd2);
        chk("abort_queue_empty", 32'(q.size()), 32'd0);
        mute = '0;
        run_vec(5'b11111, 2);

        // Abort wins over an ack in the same cycle.
        delay = 1; stage_mask = 5'b00011;
        q.push_back(0);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk("prio_ack_driven", 32'(ack[0]), 32'd1);
        do_abort();
        tick();
        chk("prio_stage_idx", 32'(stage_idx), 32'd0);
        chk("prio_queue_empty", 32'(q.size()), 32'd0);
        ack = '0;

`ifdef FSM_SEC_WATCHDOG_EN
        to_limit = 8'd4;
        stall_on_stage1();
        repeat (4) tick();
        chk("wd_not_yet", 32'(error), 32'd0);
        tick();
        chk("wd_error", 32'(error), 32'd1);
        chk("wd_stage_idx", 32'(stage_idx), 32'd1);
        chk("wd_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        chk("wd_sticky", 32'(error), 32'd1);
        do_abort();
        to_limit = 8'd0;
`else
        to_limit = 8'd4;
`endif
        // Without an effective limit the FSM waits indefinitely.
        stall_on_stage1();
        repeat (40) tick();
        chk("nowd_error", 32'(error), 32'd0);
        chk("nowd_busy", 32'(busy), 32'd1);
        chk("nowd_stage_idx", 32'(stage_idx), 32'd1);
        do_abort();
        mute = '0; to_limit = '0;

        // Asynchronous reset while a start pulse is in flight.
        delay = 2; stage_mask = 5'b11111;
        q.push_back(0);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("rst_mid_pre_start", 32'(start), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_start", 32'(start), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_pass_cnt", 32'(pass_cnt), 32'd0);
        q.delete();
        pend = 1'b0;
        exp_pass = 0;
        @(negedge clk);
        reset = 1'b0;
        run_vec(5'b00110, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fsm_secuenciador_etapas.md
Name: fsm_secuenciador_etapas

Overview:
- Parametrised successor to the five-stage data-flow control FSM.
- Sequences N_STAGES processing stages (input, vector, exponent, divider stages, etc.) through per-stage start/ack handshakes, one stage at a time, in index order 0..N_STAGES-1.
- Adds run-time stage skipping, continuous loop mode, abort, a completed-pass counter and an optional ack watchdog.
- Sits between the top-level controller and the arithmetic stage blocks.

Parameters:
- N_STAGES, 5: number of stages; legal range 2..16.
- IDX_W, 4: width of stage_idx; must be >= clog2(N_STAGES).
- PASS_W, 8: width of the pass counter.
- TO_W, 8: width of the watchdog limit and counter. Used only with the watchdog built in.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level request to execute a pass.
- loop_mode  in  1  1 = restart automatically after each pass while run=1.
- abort  in  1  synchronous abort; returns to IDLE.
- stage_mask  in  N_STAGES  1 = stage enabled, 0 = skipped. Latched when a pass begins.
- to_limit  in  TO_W  watchdog limit in cycles; 0 disables the check.
- ack  in  N_STAGES  per-stage completion acknowledge; one-cycle pulse from each stage.
- start  out  N_STAGES  per-stage start; one-cycle pulse, at most one bit high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a pass completes.
- error  out  1  sticky watchdog error.
- stage_idx  out  IDX_W  index of the current or last stage.
- pass_cnt  out  PASS_W  completed passes; wraps modulo 2^PASS_W.

Behaviour:
- Reset values: all outputs 0, state IDLE, latched mask 0.
- States: IDLE, ISSUE, WAIT, DONE, ERR. All outputs are registered.
- IDLE:
  - run=1 and abort=0 latches stage_mask.
  - If the latched mask is nonzero: go to ISSUE with stage_idx = lowest enabled index.
  - If the latched mask is zero: go to DONE.
- ISSUE:
  - Lasts exactly one cycle; start[stage_idx]=1 during it.
  - Then WAIT.
  - Latency: run sampled high at edge k gives start high during cycle k+1.
- WAIT:
  - ack is sampled only in WAIT. An ack in the same cycle as its start is ignored, so stages respond at least one cycle after start.
  - ack[stage_idx]=1 with a higher enabled stage remaining: stage_idx advances to that stage and the next state is ISSUE. The next start therefore pulses on the cycle after the ack.
  - ack[stage_idx]=1 on the last enabled stage: go to DONE.
  - ack on any other stage index is ignored.
- DONE:
  - done=1 for one cycle; pass_cnt increments.
  - Next state: ISSUE at the first enabled stage if loop_mode=1 and run=1. The mask is re-latched; if the new mask is zero, stay in DONE. Otherwise IDLE.
- run deasserted mid-pass: the current pass still completes. Only the IDLE and DONE decisions sample run.
- abort=1 in ISSUE, WAIT, DONE or ERR: next state IDLE.
  - No done pulse, pass_cnt unchanged, error cleared, stage_idx held.
  - abort takes priority over ack and over the watchdog in the same cycle.
- reset mid-operation: asynchronous return to IDLE; any start pulse in flight is removed immediately.
- stage_mask changes during a pass have no effect.

Optional Feature:
- Macro: FSM_SEC_WATCHDOG_EN.
- Defined:
  - A TO_W-bit counter clears on entry to WAIT and increments each WAIT cycle without a matching ack.
  - When it reaches to_limit (with to_limit != 0), the next state is ERR.
  - In ERR: error=1, busy=1, stage_idx holds the offending stage. Exit only via abort or reset.
  - A matching ack in the same cycle the limit is reached wins: the ack is taken and no error is raised.
- Undefined: no counter is built, WAIT waits indefinitely, error is tied to 0, and to_limit is unused.

Test Plan:
- N_STAGES=5, mask=5'b11111, run pulsed at edge 0, each stage acks 2 cycles after its start -> start pulses 00001, 00010, 00100, 01000, 10000 in order; done=1 for one cycle after ack[4]; pass_cnt=1; busy falls the cycle after done.
- mask=5'b10101 -> only start[0], start[2], start[4] pulse; stage_idx takes 0, 2, 4; ack[1] injected during WAIT on stage 2 is ignored.
- mask=0, run=1 -> no start pulses; done pulses at cycle k+1; pass_cnt increments.
- loop_mode=1, run held high for 3 passes, then low -> 3 done pulses; pass_cnt=3; start[0] is reissued the cycle after each done; return to IDLE after the pass in which run fell.
- abort asserted during WAIT on stage 2 -> IDLE next cycle; no done pulse; pass_cnt unchanged; a subsequent run starts again at stage 0.
- With FSM_SEC_WATCHDOG_EN, to_limit=4, stage 1 never acks -> error=1 five cycles after start[1]; stage_idx=1; busy stays 1; abort clears error and busy. With to_limit=0 the FSM waits indefinitely.
